// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops: clear, load, toggle,
// count up/down and shift-left, every bit advancing through the JK equation.
module jk_bank_sequencer #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_n,
  output logic [WIDTH-1:0]   j_vec,
  output logic [WIDTH-1:0]   k_vec,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_UP     = 3'd3;
  localparam logic [2:0] OP_DOWN   = 3'd4;
  localparam logic [2:0] OP_TOGGLE = 3'd5;
  localparam logic [2:0] OP_SHL    = 3'd6;

  localparam logic [COUNT_W-1:0] STEP_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] STEP_ZERO = COUNT_W'(0);

  state_t             state_r;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   qn_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   data_r;
  logic [COUNT_W-1:0] steps_r;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   up_t_s;
  logic [WIDTH-1:0]   dn_t_s;
  logic [WIDTH-1:0]   j_s;
  logic [WIDTH-1:0]   k_s;
  logic [WIDTH-1:0]   q_next_s;
  logic [COUNT_W-1:0] steps_in_s;

  // Ripple toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    up_t_s    = '0;
    dn_t_s    = '0;
    up_t_s[0] = 1'b1;
    dn_t_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t_s[i] = up_t_s[i-1] & q_r[i-1];
      dn_t_s[i] = dn_t_s[i-1] & ~q_r[i-1];
    end
  end

  // J/K drive for the current step; zero outside RUN so the bank holds
  always_comb begin
    j_s = '0;
    k_s = '0;
    if (state_r == ST_RUN) begin
      case (op_r)
        OP_CLEAR: begin
          j_s = '0;
          k_s = '1;
        end
        OP_LOAD: begin
          j_s = data_r;
          k_s = ~data_r;
        end
        OP_UP: begin
          j_s = up_t_s;
          k_s = up_t_s;
        end
        OP_DOWN: begin
          j_s = dn_t_s;
          k_s = dn_t_s;
        end
        OP_TOGGLE: begin
          j_s = data_r;
          k_s = data_r;
        end
        OP_SHL: begin
          j_s = {q_r[WIDTH-2:0], ser_in};
          k_s = ~{q_r[WIDTH-2:0], ser_in};
        end
        default: begin
          j_s = '0;
          k_s = '0;
        end
      endcase
    end else begin
      j_s = '0;
      k_s = '0;
    end
  end

  // JK next-state equation shared by every bit
  always_comb begin
    q_next_s = (j_s & ~q_r) | (~k_s & q_r);
  end

  // Multi-step ops take max(count,1) steps; all others take one
  always_comb begin
    steps_in_s = STEP_ONE;
    case (cmd_op)
      OP_UP, OP_DOWN, OP_SHL: begin
        if (cmd_count == STEP_ZERO) begin
          steps_in_s = STEP_ONE;
        end else begin
          steps_in_s = cmd_count;
        end
      end
      default: steps_in_s = STEP_ONE;
    endcase
  end

  // Control FSM, bank state and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      q_r     <= '0;
      qn_r    <= '1;
      op_r    <= OP_NOP;
      data_r  <= '0;
      steps_r <= STEP_ZERO;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      q_r  <= q_next_s;
      qn_r <= ~q_next_s;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && ready_r) begin
            op_r    <= cmd_op;
            data_r  <= cmd_data;
            steps_r <= steps_in_s;
            state_r <= ST_RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          steps_r <= steps_r - STEP_ONE;
          if (steps_r == STEP_ONE) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign q         = q_r;
  assign q_n       = qn_r;
  assign j_vec     = j_s;
  assign k_vec     = k_s;

endmodule
